regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Write-back queue and write-port controller for the MIPS register bank. It accepts write-back requests from the ALU path and the load (memory) path and buffers them in a small FIFO. It drains the FIFO into the register bank's single write port (enable, 5-bit address, 32-bit data), one write per cycle unless the port is stalled. It also gives the decode stage a forwarding lookup of writes that are still queued and not yet committed.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- alu_valid  input  1  ALU write-back request present.
- alu_addr  input  5  ALU destination register.
- alu_data  input  32  ALU result.
- alu_ready  output  1  ALU request accepted this cycle when high with alu_valid.
- mem_valid  input  1  load write-back request present.
- mem_addr  input  5  load destination register.
- mem_data  input  32  load data.
- mem_ready  output  1  load request accepted this cycle when high with mem_valid.
- wr_stall  input  1  register bank write port unavailable this cycle.
- rf_we  output  1  register bank write enable.
- rf_wa  output  5  register bank write address.
- rf_wd  output  32  register bank write data.
- fwd_addr  input  5  forwarding lookup address.
- fwd_hit  output  1  a queued entry targets fwd_addr.
- fwd_data  output  32  data of the youngest queued entry targeting fwd_addr.
- count  output  log2(DEPTH)+1  entries currently queued.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.

## Operation
- Storage: circular FIFO of DEPTH entries, each {addr[4:0], data[31:0]}, with read pointer, write pointer and count registers.
- Ready rules use the registered count only; a same-cycle dequeue gives no credit:
  - mem_ready = (count < DEPTH).
  - alu_ready = (count < DEPTH - 1) when mem_valid && mem_ready; otherwise (count < DEPTH).
- Enqueue order in one cycle: the mem entry goes in first (older), then the alu entry. Up to 2 enqueues per cycle.
- Writes to $0: a request with addr == 0 is accepted (handshake completes normally) but is not enqueued and never reaches rf_we.
- Drain: rf_we = !empty && !wr_stall; rf_wa/rf_wd = head entry. Head is dequeued on the edge where rf_we = 1.
- When rf_we = 0, rf_wa and rf_wd hold the head entry, or 0 when the FIFO is empty.
- count update: count_next = count + enqueues − dequeue. Enqueue and dequeue in the same cycle are legal, including at full. At full, readies are low, so only a dequeue occurs.
- Forwarding (combinational):
  - Scan the valid entries from head to tail. fwd_hit = 1 if any entry's addr equals fwd_addr and fwd_addr != 0.
  - fwd_data = data of the youngest match; 0 when there is no hit.
  - Same-cycle incoming requests are not included in the scan.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (asynchronous assert, synchronous release at the next edge): pointers = 0, count = 0, rf_we = 0, rf_wa = 0, rf_wd = 0, fwd_hit = 0, fwd_data = 0, empty = 1, full = 0.
- While the FIFO is empty after reset, alu_ready = mem_ready = 1.
- Reset asserted mid-operation discards all queued entries with no commit.
- Latency: a request accepted at edge N is visible at rf_we in the cycle after edge N, if it is at the head and not stalled. It commits at edge N+1. No bypass from request to write port.
- Throughput: 1 commit per cycle. Sustained dual-source input fills the FIFO at a net +1 per cycle.
- alu_ready depends combinationally on mem_valid. Neither ready depends on alu_valid.
- wr_stall affects the current cycle only; the head is held, not dropped.

## Test plan
- Reset then single ALU write: alu {addr 5, data 0xDEADBEEF} accepted at edge 1 -> rf_we = 1, rf_wa = 5, rf_wd = 0xDEADBEEF in cycle 2; empty = 1 after edge 2.
- Dual enqueue ordering: mem {3, 0x11} and alu {3, 0x22} in the same cycle with wr_stall = 1 -> count = 2, fwd_addr = 3 gives fwd_hit = 1, fwd_data = 0x22. Release stall -> commits 0x11 then 0x22 on consecutive edges.
- Fill and backpressure (DEPTH = 4, wr_stall = 1):
  - Enqueue 3 entries; then mem_valid and alu_valid together -> mem_ready = 1, alu_ready = 0.
  - Next cycle both readies are 0, full = 1.
  - Deassert stall -> one dequeue per cycle; readies return when count < 4.
- $0 drop: alu {0, 0x55} -> alu_ready = 1, count unchanged, rf_we never asserts for addr 0; fwd_addr = 0 gives fwd_hit = 0.
- Wrap-around: 10 back-to-back single writes with alternating stall -> all 10 commit in order with correct data, pointers wrap without loss.
- Reset mid-operation: 3 entries queued, assert reset -> rf_we = 0 and count = 0 immediately; after release, no stale entry commits.

Source files
------------

// File: rtl/regfile_writeback.sv
// Write-back queue for the register bank: buffers ALU/load results, drains one per
// cycle into the single write port, and offers a forwarding lookup of queued writes.
module regfile_writeback #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_addr,
  input  logic [31:0]              alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [4:0]               mem_addr,
  input  logic [31:0]              mem_data,
  output logic                     mem_ready,
  input  logic                     wr_stall,
  output logic                     rf_we,
  output logic [4:0]               rf_wa,
  output logic [31:0]              rf_wd,
  input  logic [4:0]               fwd_addr,
  output logic                     fwd_hit,
  output logic [31:0]              fwd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [4:0]    addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count_q;

  logic          space_one;
  logic          space_two;
  logic          mem_take;
  logic          mem_enq;
  logic          alu_enq;
  logic          deq;
  logic [AW-1:0] alu_slot;

  // Readies look only at the registered count; a same-cycle drain gives no credit.
  assign space_one = count_q < CW'(DEPTH);
  assign space_two = count_q < CW'(DEPTH - 1);
  assign mem_ready = space_one;
  assign mem_take  = mem_valid && space_one;
  assign alu_ready = mem_take ? space_two : space_one;

  // Writes to $0 complete the handshake but are never queued.
  assign mem_enq  = mem_take && (mem_addr != 5'd0);
  assign alu_enq  = alu_valid && alu_ready && (alu_addr != 5'd0);
  assign alu_slot = wr_ptr + AW'(mem_enq);

  assign count = count_q;
  assign empty = (count_q == CW'(0));
  assign full  = (count_q == CW'(DEPTH));

  assign rf_we = !empty && !wr_stall;
  assign rf_wa = empty ? 5'd0 : addr_mem[rd_ptr];
  assign rf_wd = empty ? 32'd0 : data_mem[rd_ptr];
  assign deq   = rf_we;

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr + AW'(mem_enq) + AW'(alu_enq);
      rd_ptr  <= rd_ptr + AW'(deq);
      count_q <= count_q + CW'(mem_enq) + CW'(alu_enq) - CW'(deq);
    end
  end

  // Entry storage; the load result is older, so it takes the first free slot.
  always_ff @(posedge clk) begin
    if (mem_enq) begin
      addr_mem[wr_ptr] <= mem_addr;
      data_mem[wr_ptr] <= mem_data;
    end
    if (alu_enq) begin
      addr_mem[alu_slot] <= alu_addr;
      data_mem[alu_slot] <= alu_data;
    end
  end

  // Head-to-tail scan; later matches overwrite earlier ones so the youngest wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 32'd0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) && (fwd_addr != 5'd0) &&
          (addr_mem[rd_ptr + AW'(i)] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[rd_ptr + AW'(i)];
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed vector table, wrap and reset sequences,
// then randomized traffic against a queue-based reference model.
module tb_regfile_writeback;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid, mem_valid, wr_stall;
  logic [4:0]    alu_addr, mem_addr, fwd_addr;
  logic [31:0]   alu_data, mem_data;
  logic          alu_ready, mem_ready, rf_we, fwd_hit, empty, full;
  logic [4:0]    rf_wa;
  logic [31:0]   rf_wd, fwd_data;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .wr_stall(wr_stall), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic mv; logic [4:0] ma; logic [31:0] md;
    logic av; logic [4:0] aa; logic [31:0] ad;
    logic st; logic [4:0] fa;
    logic mr; logic ar; logic we; logic [4:0] wa; logic [31:0] wd;
    logic hit; logic [31:0] fd; int cnt;
  } vec_t;

  typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;

  vec_t tbl[$];
  ent_t mq[$];
  ent_t commits[$];
  logic rec_en = 1'b0;
  logic e_mr, e_ar, e_we;

  always @(negedge clk) begin
    if (rec_en && rf_we) commits.push_back('{rf_wa, rf_wd});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic st, input logic [4:0] fa);
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    wr_stall  = st; fwd_addr = fa;
  endtask

  task automatic add(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                     input logic av, input logic [4:0] aa, input logic [31:0] ad,
                     input logic st, input logic [4:0] fa,
                     input logic mr, input logic ar, input logic we, input logic [4:0] wa,
                     input logic [31:0] wd, input logic hit, input logic [31:0] fd, input int cnt);
    vec_t v;
    v.mv = mv; v.ma = ma; v.md = md; v.av = av; v.aa = aa; v.ad = ad; v.st = st; v.fa = fa;
    v.mr = mr; v.ar = ar; v.we = we; v.wa = wa; v.wd = wd; v.hit = hit; v.fd = fd; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  // Reference: a plain queue; expectations derived from its size and contents.
  task automatic model_check(input string tag);
    int n;
    logic hit;
    logic [31:0] fd;
    n    = mq.size();
    e_mr = (n < DEPTH);
    e_ar = (mem_valid && e_mr) ? (n + 1 < DEPTH) : (n < DEPTH);
    e_we = (n > 0) && !wr_stall;
    hit  = 1'b0;
    fd   = 32'd0;
    foreach (mq[i]) begin
      if (fwd_addr != 5'd0 && mq[i].a == fwd_addr) begin
        hit = 1'b1;
        fd  = mq[i].d;
      end
    end
    chk({tag, ".mem_ready"}, 32'(mem_ready), 32'(e_mr));
    chk({tag, ".alu_ready"}, 32'(alu_ready), 32'(e_ar));
    chk({tag, ".rf_we"}, 32'(rf_we), 32'(e_we));
    chk({tag, ".rf_wa"}, 32'(rf_wa), (n > 0) ? 32'(mq[0].a) : 32'd0);
    chk({tag, ".rf_wd"}, rf_wd, (n > 0) ? mq[0].d : 32'd0);
    chk({tag, ".fwd_hit"}, 32'(fwd_hit), 32'(hit));
    chk({tag, ".fwd_data"}, fwd_data, fd);
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
  endtask

  task automatic model_update();
    if (e_we) void'(mq.pop_front());
    if (mem_valid && e_mr && mem_addr != 5'd0) mq.push_back('{mem_addr, mem_data});
    if (alu_valid && e_ar && alu_addr != 5'd0) mq.push_back('{alu_addr, alu_data});
  endtask

  initial begin
    int k, cyc;
    logic acc;
    string nm;

    // Reset state.
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("rst.rf_we", 32'(rf_we), 0);
    chk("rst.rf_wa", 32'(rf_wa), 0);
    chk("rst.rf_wd", rf_wd, 0);
    chk("rst.count", 32'(count), 0);
    chk("rst.empty", 32'(empty), 1);
    chk("rst.full", 32'(full), 0);
    chk("rst.fwd_hit", 32'(fwd_hit), 0);
    chk("rst.fwd_data", fwd_data, 0);
    chk("rst.mem_ready", 32'(mem_ready), 1);
    chk("rst.alu_ready", 32'(alu_ready), 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Single write, dual ordering, fill/backpressure, $0 drops.
    add(0,0,0,        1,5,32'hDEADBEEF, 0,0, 1,1,0,0,0,0,0,0);
    add(0,0,0,        0,0,0,            0,5, 1,1,1,5,32'hDEADBEEF,1,32'hDEADBEEF,1);
    add(0,0,0,        0,0,0,            0,5, 1,1,0,0,0,0,0,0);
    add(1,3,32'h11,   1,3,32'h22,       1,3, 1,1,0,0,0,0,0,0);
    add(0,0,0,        0,0,0,            1,3, 1,1,0,3,32'h11,1,32'h22,2);
    add(0,0,0,        0,0,0,            0,3, 1,1,1,3,32'h11,1,32'h22,2);
    add(0,0,0,        0,0,0,            0,3, 1,1,1,3,32'h22,1,32'h22,1);
    add(0,0,0,        0,0,0,            0,3, 1,1,0,0,0,0,0,0);
    add(0,0,0,        1,1,32'h101,      1,1, 1,1,0,0,0,0,0,0);
    add(0,0,0,        1,2,32'h102,      1,1, 1,1,0,1,32'h101,1,32'h101,1);
    add(0,0,0,        1,1,32'h103,      1,1, 1,1,0,1,32'h101,1,32'h101,2);
    add(1,4,32'h104,  1,5,32'h105,      1,1, 1,0,0,1,32'h101,1,32'h103,3);
    add(1,4,32'h104,  1,5,32'h105,      1,4, 0,0,0,1,32'h101,1,32'h104,4);
    add(0,0,0,        0,0,0,            0,4, 0,0,1,1,32'h101,1,32'h104,4);
    add(0,0,0,        0,0,0,            0,4, 1,1,1,2,32'h102,1,32'h104,3);
    add(0,0,0,        0,0,0,            0,4, 1,1,1,1,32'h103,1,32'h104,2);
    add(0,0,0,        0,0,0,            0,4, 1,1,1,4,32'h104,1,32'h104,1);
    add(0,0,0,        0,0,0,            0,4, 1,1,0,0,0,0,0,0);
    add(0,0,0,        1,0,32'h55,       0,0, 1,1,0,0,0,0,0,0);
    add(0,0,0,        0,0,0,            0,0, 1,1,0,0,0,0,0,0);
    add(1,0,32'h66,   1,6,32'h77,       0,6, 1,1,0,0,0,0,0,0);
    add(0,0,0,        0,0,0,            0,6, 1,1,1,6,32'h77,1,32'h77,1);
    add(0,0,0,        0,0,0,            0,6, 1,1,0,0,0,0,0,0);

    foreach (tbl[i]) begin
      drive(tbl[i].mv, tbl[i].ma, tbl[i].md, tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].st, tbl[i].fa);
      #3;
      nm = $sformatf("vec%0d", i);
      chk({nm, ".mem_ready"}, 32'(mem_ready), 32'(tbl[i].mr));
      chk({nm, ".alu_ready"}, 32'(alu_ready), 32'(tbl[i].ar));
      chk({nm, ".rf_we"}, 32'(rf_we), 32'(tbl[i].we));
      chk({nm, ".rf_wa"}, 32'(rf_wa), 32'(tbl[i].wa));
      chk({nm, ".rf_wd"}, rf_wd, tbl[i].wd);
      chk({nm, ".fwd_hit"}, 32'(fwd_hit), 32'(tbl[i].hit));
      chk({nm, ".fwd_data"}, fwd_data, tbl[i].fd);
      chk({nm, ".count"}, 32'(count), 32'(tbl[i].cnt));
      chk({nm, ".empty"}, 32'(empty), 32'(tbl[i].cnt == 0));
      chk({nm, ".full"}, 32'(full), 32'(tbl[i].cnt == DEPTH));
      @(posedge clk); #1;
    end

    // Wrap-around: 10 writes under alternating stall, then drain.
    commits.delete();
    rec_en = 1'b1;
    k = 0;
    cyc = 0;
    while (k < 10 && cyc < 200) begin
      drive(0, 0, 0, 1, 5'(k + 1), 32'hA5A50000 + 32'(k), cyc[0], 0);
      #3;
      acc = alu_ready;
      @(posedge clk); #1;
      if (acc) k++;
      cyc++;
    end
    chk("wrap.accepted", 32'(k), 10);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (12) @(posedge clk);
    #1;
    rec_en = 1'b0;
    chk("wrap.commits", 32'(commits.size()), 10);
    foreach (commits[i]) begin
      if (i < 10) begin
        chk($sformatf("wrap.addr%0d", i), 32'(commits[i].a), 32'(i + 1));
        chk($sformatf("wrap.data%0d", i), commits[i].d, 32'hA5A50000 + 32'(i));
      end
    end

    // Randomized traffic against the queue model.
    mq.delete();
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)));
      #3;
      model_check($sformatf("rnd%0d", c));
      @(posedge clk); #1;
      model_update();
    end

    // Reset mid-operation discards queued entries.
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 5'(7 + i), 32'hC0DE0000 + 32'(i), 1, 0);
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 7);
    #1;
    chk("mid.count_before", 32'(count), 3);
    chk("mid.we_before", 32'(rf_we), 1);
    reset = 1'b0;
    #1;
    chk("mid.rf_we", 32'(rf_we), 0);
    chk("mid.count", 32'(count), 0);
    chk("mid.empty", 32'(empty), 1);
    chk("mid.fwd_hit", 32'(fwd_hit), 0);
    @(negedge clk);
    reset = 1'b1;
    commits.delete();
    rec_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rec_en = 1'b0;
    chk("mid.stale_commits", 32'(commits.size()), 0);
    chk("mid.count_after", 32'(count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
